// File: rtl/uart_autobaud_detect.sv
`timescale 1ns/1ps
// uart_autobaud_detect
// Measures the bit period of an incoming 0x55 sync character on the UART RX
// line, counted in i_ref_clk cycles. The result feeds the divider ratio
// computation of the RX/TX prescale logic.
//
// Ports
//   i_ref_clk     single clock, all logic on rising edge
//   i_rst_n       synchronous active-low reset
//   i_enable      1 = run/hold detection, 0 = abort and clear lock
//   i_rx_in       asynchronous serial line, idle high
//   o_bit_period  last valid measured bit period, held until the next valid one
//   o_valid       1-cycle pulse when o_bit_period updates
//   o_error       1-cycle pulse on a rejected measurement
//   o_locked      high from o_valid until i_enable drops
//   o_busy        high while a measurement is running
//
// Optional feature: define AUTOBAUD_TOL_CHECK_EN to reject frames whose
// edge-to-edge segments differ from the start-bit length by more than 25%.
module uart_autobaud_detect #(
    parameter int CNT_WIDTH  = 16,
    parameter int IDLE_MIN   = 8,
    parameter int MIN_PERIOD = 4
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_rx_in,
    output logic [CNT_WIDTH-1:0] o_bit_period,
    output logic                 o_valid,
    output logic                 o_error,
    output logic                 o_locked,
    output logic                 o_busy
);

    localparam int TOT_W  = CNT_WIDTH + 3;
    localparam int IDLE_W = $clog2(IDLE_MIN + 1);

    typedef enum logic [2:0] {IDLE, ARMED, MEASURE, DONE, LOCKED} state_t;

    state_t                state_reg, state_next;
    logic                  sync1_reg, sync2_reg, prev_reg;
    logic [IDLE_W-1:0]     idle_cnt_reg, idle_cnt_next;
    logic [TOT_W-1:0]      total_reg, total_next;
    logic [2:0]            edge_cnt_reg, edge_cnt_next;
    logic [CNT_WIDTH-1:0]  period_reg, period_next;
    logic                  valid_reg, valid_next;
    logic                  error_reg, error_next;
    logic                  locked_reg, locked_next;
    logic                  line_edge, line_fall;
    logic [CNT_WIDTH:0]    period_full;
    logic                  period_reject;
`ifdef AUTOBAUD_TOL_CHECK_EN
    logic [TOT_W-1:0]      seg_reg, seg_next;
    logic [TOT_W-1:0]      s0_reg, s0_next;
    logic [TOT_W-1:0]      seg_diff;
    logic                  seg_ok;

    assign seg_diff = (seg_reg >= s0_reg) ? (seg_reg - s0_reg) : (s0_reg - seg_reg);
    assign seg_ok   = (seg_diff <= (s0_reg >> 2));
`endif

    assign line_edge = sync2_reg ^ prev_reg;
    assign line_fall = prev_reg & ~sync2_reg;

    // Round-half-up of total/8, kept one bit wider than the output so a
    // result that no longer fits CNT_WIDTH is rejected instead of wrapping.
    assign period_full   = (CNT_WIDTH+1)'(({1'b0, total_reg} + (TOT_W+1)'(4)) >> 3);
    assign period_reject = (period_full < (CNT_WIDTH+1)'(MIN_PERIOD)) || period_full[CNT_WIDTH];

    always_comb begin
        state_next    = state_reg;
        total_next    = total_reg;
        edge_cnt_next = edge_cnt_reg;
        period_next   = period_reg;
        valid_next    = 1'b0;
        error_next    = 1'b0;
        locked_next   = locked_reg;
`ifdef AUTOBAUD_TOL_CHECK_EN
        seg_next      = seg_reg;
        s0_next       = s0_reg;
`endif
        // Idle qualification only accumulates while sitting in IDLE, so any
        // return to IDLE forces the line to re-qualify from zero.
        idle_cnt_next = '0;
        if (state_reg == IDLE && sync2_reg) begin
            idle_cnt_next = (idle_cnt_reg == IDLE_W'(IDLE_MIN)) ? idle_cnt_reg
                                                                : idle_cnt_reg + IDLE_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (i_enable && idle_cnt_reg == IDLE_W'(IDLE_MIN))
                    state_next = ARMED;
            end
            ARMED: begin
                if (!i_enable) begin
                    state_next = IDLE;
                end else if (line_fall) begin
                    state_next    = MEASURE;
                    total_next    = TOT_W'(1);
                    edge_cnt_next = '0;
`ifdef AUTOBAUD_TOL_CHECK_EN
                    seg_next      = TOT_W'(1);
`endif
                end
            end
            MEASURE: begin
                total_next = total_reg + TOT_W'(1);
`ifdef AUTOBAUD_TOL_CHECK_EN
                seg_next   = seg_reg + TOT_W'(1);
`endif
                if (!i_enable) begin
                    state_next = IDLE;
                end else if (total_reg == '1) begin
                    // Timeout wins over a coincident edge.
                    state_next = IDLE;
                    error_next = 1'b1;
                end else if (line_edge) begin
                    edge_cnt_next = edge_cnt_reg + 3'd1;
`ifdef AUTOBAUD_TOL_CHECK_EN
                    seg_next = TOT_W'(1);
                    if (edge_cnt_reg == 3'd0) begin
                        s0_next = seg_reg;
                    end else if (!seg_ok) begin
                        state_next = IDLE;
                        error_next = 1'b1;
                    end
                    if (seg_ok || edge_cnt_reg == 3'd0) begin
`else
                    begin
`endif
                        // The 8th edge opens d7: total already spans 8 bits,
                        // so it is frozen here rather than incremented.
                        if (edge_cnt_reg == 3'd7) begin
                            state_next = DONE;
                            total_next = total_reg;
                        end
                    end
                end
            end
            DONE: begin
                if (!i_enable) begin
                    state_next = IDLE;
                end else if (period_reject) begin
                    state_next = IDLE;
                    error_next = 1'b1;
                end else begin
                    state_next  = LOCKED;
                    period_next = period_full[CNT_WIDTH-1:0];
                    valid_next  = 1'b1;
                    locked_next = 1'b1;
                end
            end
            LOCKED: begin
                if (!i_enable) begin
                    state_next  = IDLE;
                    locked_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            prev_reg     <= 1'b1;
            idle_cnt_reg <= '0;
            total_reg    <= '0;
            edge_cnt_reg <= '0;
            period_reg   <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            locked_reg   <= 1'b0;
`ifdef AUTOBAUD_TOL_CHECK_EN
            seg_reg      <= '0;
            s0_reg       <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            sync1_reg    <= i_rx_in;
            sync2_reg    <= sync1_reg;
            prev_reg     <= sync2_reg;
            idle_cnt_reg <= idle_cnt_next;
            total_reg    <= total_next;
            edge_cnt_reg <= edge_cnt_next;
            period_reg   <= period_next;
            valid_reg    <= valid_next;
            error_reg    <= error_next;
            locked_reg   <= locked_next;
`ifdef AUTOBAUD_TOL_CHECK_EN
            seg_reg      <= seg_next;
            s0_reg       <= s0_next;
`endif
        end
    end

    assign o_bit_period = period_reg;
    assign o_valid      = valid_reg;
    assign o_error      = error_reg;
    assign o_locked     = locked_reg;
    assign o_busy       = (state_reg == MEASURE);

endmodule

// File: tb/tb_uart_autobaud_detect.sv
`timescale 1ns/1ps
// Testbench for uart_autobaud_detect: directed sync frames plus randomized
// frames judged by a frame-level reference model (sum of bit lengths,
// rounding, rejection rules).
module tb_uart_autobaud_detect;

    localparam int CW   = 5;
    localparam int IMIN = 8;
    localparam int MINP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rx = 1'b1;
    logic [CW-1:0] bit_period;
    logic          valid, error, locked, busy;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    int both_cnt = 0;
    int exp_period = 0;
    int seg[8];

    uart_autobaud_detect #(
        .CNT_WIDTH(CW),
        .IDLE_MIN(IMIN),
        .MIN_PERIOD(MINP)
    ) dut (
        .i_ref_clk(clk),
        .i_rst_n(rst_n),
        .i_enable(enable),
        .i_rx_in(rx),
        .o_bit_period(bit_period),
        .o_valid(valid),
        .o_error(error),
        .o_locked(locked),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) valid_cnt++;
        if (error) error_cnt++;
        if (valid && error) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // start, d0..d6 from seg[], then d7 (low) and the line returns high
    task automatic send_frame(input int d7_len);
        for (int k = 0; k < 8; k++) hold((k % 2) ? 1'b1 : 1'b0, seg[k]);
        hold(1'b0, d7_len);
        rx = 1'b1;
    endtask

    // Frame-level expectation: period = round(sum/8); reject on timeout,
    // too-small or unrepresentable period, and (optionally) segment tolerance.
    task automatic model(output bit bad, output int p);
        int sum = 0;
        for (int k = 0; k < 8; k++) sum += seg[k];
        p = (sum + 4) / 8;
        bad = (sum >= (1 << (CW + 3)) - 1) || (p < MINP) || (p >= (1 << CW));
`ifdef AUTOBAUD_TOL_CHECK_EN
        for (int k = 1; k < 8; k++) begin
            int d = (seg[k] > seg[0]) ? seg[k] - seg[0] : seg[0] - seg[k];
            if (d > seg[0] / 4) bad = 1'b1;
        end
`endif
    endtask

    task automatic run_and_check(input string tag, input bit while_locked);
        int v0 = valid_cnt;
        int e0 = error_cnt;
        int p;
        bit bad;
        model(bad, p);
        send_frame(seg[0]);
        hold(1'b1, 8);
        if (while_locked) begin
            check({tag, ".valid"}, valid_cnt - v0, 0);
            check({tag, ".error"}, error_cnt - e0, 0);
            check({tag, ".locked"}, locked, 1);
        end else if (bad) begin
            check({tag, ".valid"}, valid_cnt - v0, 0);
            check({tag, ".error"}, error_cnt - e0, 1);
            check({tag, ".locked"}, locked, 0);
        end else begin
            exp_period = p;
            check({tag, ".valid"}, valid_cnt - v0, 1);
            check({tag, ".error"}, error_cnt - e0, 0);
            check({tag, ".locked"}, locked, 1);
        end
        check({tag, ".period"}, bit_period, exp_period);
        $display("frame %s sum-model period %0d bad %0d -> period %0d locked %0d",
                 tag, p, bad, bit_period, locked);
    endtask

    task automatic relock(input int idle);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        hold(1'b1, idle);
    endtask

    initial begin
        int v0, e0;
        @(negedge clk);
        // 1. reset with line high
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.period", bit_period, 0);
        check("rst.valid", valid, 0);
        check("rst.error", error, 0);
        check("rst.locked", locked, 0);
        check("rst.busy", busy, 0);
        rst_n = 1'b1;
        v0 = valid_cnt; e0 = error_cnt;
        hold(1'b1, 5);
        check("rel.valid", valid_cnt - v0, 0);
        check("rel.error", error_cnt - e0, 0);

        // 2. 16 cycles/bit, then a second frame while locked
        enable = 1'b1;
        hold(1'b1, 20);
        for (int k = 0; k < 8; k++) seg[k] = 16;
        run_and_check("t2", 1'b0);
        check("t2.const", bit_period, 16);
        hold(1'b1, 20);
        run_and_check("t2_locked", 1'b1);

        // 3. alternating 10/11, total 84
        relock(20);
        for (int k = 0; k < 8; k++) seg[k] = (k % 2) ? 11 : 10;
        run_and_check("t3", 1'b0);
        check("t3.const", bit_period, 11);

        // 4. 2 cycles/bit rejected
        relock(20);
        for (int k = 0; k < 8; k++) seg[k] = 2;
        run_and_check("t4", 1'b0);
        check("t4.busy", busy, 0);

        // 5. timeout with the line stuck low, then abort mid-measure
        hold(1'b1, 12);
        v0 = valid_cnt; e0 = error_cnt;
        hold(1'b0, 200);
        check("t5.busy_mid", busy, 1);
        check("t5.err_early", error_cnt - e0, 0);
        hold(1'b0, 70);
        check("t5.timeout_err", error_cnt - e0, 1);
        check("t5.timeout_valid", valid_cnt - v0, 0);
        check("t5.busy_after", busy, 0);
        hold(1'b1, 12);
        v0 = valid_cnt; e0 = error_cnt;
        hold(1'b0, 20);
        check("t5.abort_busy_pre", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        check("t5.abort_busy", busy, 0);
        hold(1'b1, 3);
        check("t5.abort_valid", valid_cnt - v0, 0);
        check("t5.abort_error", error_cnt - e0, 0);
        $display("timeout/abort done");

        // 6. start 16, d3 stretched to 24
        relock(20);
        for (int k = 0; k < 8; k++) seg[k] = 16;
        seg[4] = 24;
        run_and_check("t6", 1'b0);
`ifndef AUTOBAUD_TOL_CHECK_EN
        check("t6.const", bit_period, 17);
`endif

        // randomized frames
        for (int i = 0; i < 20; i++) begin
            int base = $urandom_range(2, 24);
            relock($urandom_range(12, 30));
            if ($urandom_range(0, 5) == 0) begin
                int k = $urandom_range(2, 6);
                for (int j = 0; j < 8; j++) seg[j] = base;
                v0 = valid_cnt; e0 = error_cnt;
                for (int j = 0; j < k; j++) hold((j % 2) ? 1'b1 : 1'b0, seg[j]);
                enable = 1'b0;
                rx = 1'b1;
                @(negedge clk);
                check($sformatf("rnd%0d.abort_busy", i), busy, 0);
                repeat (4) @(negedge clk);
                check($sformatf("rnd%0d.abort_pulses", i), (valid_cnt - v0) + (error_cnt - e0), 0);
                $display("frame rnd%0d aborted after %0d segments base %0d", i, k, base);
            end else begin
                for (int j = 0; j < 8; j++) begin
                    seg[j] = base + $urandom_range(0, 2) - 1;
                    if (seg[j] < 2) seg[j] = 2;
                end
                if ($urandom_range(0, 3) == 0) seg[$urandom_range(1, 7)] += base / 2 + 2;
                run_and_check($sformatf("rnd%0d", i), 1'b0);
            end
        end

        // reset in the middle of a measurement clears everything
        relock(20);
        for (int k = 0; k < 3; k++) hold((k % 2) ? 1'b1 : 1'b0, 16);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst.period", bit_period, 0);
        check("mid_rst.busy", busy, 0);
        check("mid_rst.locked", locked, 0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        check("no_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
